conv_window_gen: RTL and testbench

Downstream consumer of the feature-map assembly stage. Once a complete m x n matrix is latched upstream (its `full` flag drives `start`), this block walks the matrix in raster order and presents one K x K window per output position on a valid/ready stream to the convolution MAC array. The stride is selectable per run. No padding is applied: only fully in-bounds windows are emitted.

---
 rtl/conv_window_gen.sv | 152 +++++++++++++++
 tb/tb_conv_window_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: walks a latched m x n matrix in raster order and streams
// every fully in-bounds K x K window on a valid/ready interface.
module conv_window_gen #(
    parameter int unsigned BITS = 8,
    parameter int unsigned DIM  = 32,
    parameter int unsigned K    = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [$clog2(DIM):0]                m,
    input  logic [$clog2(DIM):0]                n,
    input  logic [1:0]                          stride,
    input  logic [DIM-1:0][DIM-1:0][BITS-1:0]   MTX,
    output logic [K-1:0][K-1:0][BITS-1:0]       WIN,
    output logic [$clog2(DIM):0]                win_row,
    output logic [$clog2(DIM):0]                win_col,
    output logic                                valid,
    input  logic                                ready,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int unsigned AW = $clog2(DIM);  // matrix index width
    localparam int unsigned W  = AW + 1;       // dimension / coordinate width
    localparam int unsigned PW = W + 1;        // position arithmetic, overflow-free

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                         state_q, state_d;
    logic [W-1:0]                   m_q, m_d, n_q, n_d;
    logic [W-1:0]                   r_q, r_d, c_q, c_d;
    logic [1:0]                     stride_q, stride_d;
    logic [K-1:0][K-1:0][BITS-1:0]  win_q, win_d;
    logic                           err_q, err_d;

    logic [PW-1:0]                  c_adv, r_adv;
    logic                           wrap, last, bad_dim, load;
    logic [W-1:0]                   ld_r, ld_c;

    // Next raster position and end-of-row / end-of-matrix detection
    always_comb begin
        c_adv   = PW'(c_q) + PW'(stride_q);
        r_adv   = PW'(r_q) + PW'(stride_q);
        wrap    = (c_adv + PW'(K)) > PW'(m_q);
        last    = wrap && ((r_adv + PW'(K)) > PW'(n_q));
        bad_dim = (m < W'(K)) || (n < W'(K));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; valid is high throughout RUN so ready alone marks a handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && !bad_dim) state_d = StRun;
            StRun:   if (ready && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        valid = (state_q == StRun);
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
    end

    // Datapath next state: latch run parameters, step position, reload window
    always_comb begin
        m_d      = m_q;
        n_d      = n_q;
        stride_d = stride_q;
        r_d      = r_q;
        c_d      = c_q;
        win_d    = win_q;
        err_d    = 1'b0;
        ld_r     = r_q;
        ld_c     = c_q;
        load     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d      = m;
                    n_d      = n;
                    stride_d = (stride == 2'd0) ? 2'd1 : stride;
                    if (bad_dim) begin
                        err_d = 1'b1;
                    end else begin
                        ld_r = '0;
                        ld_c = '0;
                        load = 1'b1;
                    end
                end
            end
            StRun: begin
                // On the last window, hold everything; DONE drops valid
                if (ready && !last) begin
                    ld_r = wrap ? W'(r_adv) : r_q;
                    ld_c = wrap ? '0 : W'(c_adv);
                    load = 1'b1;
                end
            end
            default: ;
        endcase
        if (load) begin
            r_d = ld_r;
            c_d = ld_c;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_d[i][j] = MTX[AW'(ld_r + W'(i))][AW'(ld_c + W'(j))];
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      <= '0;
            n_q      <= '0;
            stride_q <= '0;
            r_q      <= '0;
            c_q      <= '0;
            win_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            m_q      <= m_d;
            n_q      <= n_d;
            stride_q <= stride_d;
            r_q      <= r_d;
            c_q      <= c_d;
            win_q    <= win_d;
            err_q    <= err_d;
        end
    end

    assign WIN     = win_q;
    assign win_row = r_q;
    assign win_col = c_q;
    assign err     = err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed runs with a position scoreboard.
module tb_conv_window_gen;

    localparam int BITS = 8;
    localparam int DIM  = 32;
    localparam int K    = 3;
    localparam int W    = $clog2(DIM) + 1;

    typedef logic [K-1:0][K-1:0][BITS-1:0] win_t;
    typedef struct {
        int r;
        int c;
    } pos_t;

    logic                               clk    = 1'b0;
    logic                               rst_n  = 1'b1;
    logic                               start  = 1'b0;
    logic                               ready  = 1'b0;
    logic [W-1:0]                       m      = '0;
    logic [W-1:0]                       n      = '0;
    logic [1:0]                         stride = '0;
    logic [DIM-1:0][DIM-1:0][BITS-1:0]  mtx;
    win_t                               win;
    logic [W-1:0]                       win_row, win_col;
    logic                               valid, busy, done, err;

    conv_window_gen #(
        .BITS(BITS),
        .DIM (DIM),
        .K   (K)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .m      (m),
        .n      (n),
        .stride (stride),
        .MTX    (mtx),
        .WIN    (win),
        .win_row(win_row),
        .win_col(win_col),
        .valid  (valid),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    pos_t exp_q[$];
    win_t acc_win[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_n, done_n, err_n, busy_n;
    int   first_hs, last_hs, done_cyc, err_cyc, last_r, last_c;

    function automatic logic [BITS-1:0] pix(input int r, input int c);
        return BITS'(16 * r + c);
    endfunction

    function automatic win_t model_win(input int r, input int c);
        win_t w;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[i][j] = pix(r + i, c + j);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected window positions for one run, from the window-count formulas
    task automatic push_run(input int mm, input int nn, input int s);
        pos_t p;
        int   ss;
        ss = (s == 0) ? 1 : s;
        for (int r = 0; r + K <= nn; r += ss)
            for (int c = 0; c + K <= mm; c += ss) begin
                p.r = r;
                p.c = c;
                exp_q.push_back(p);
            end
    endtask

    task automatic set_dims(input int mm, input int nn, input int s);
        m      = W'(mm);
        n      = W'(nn);
        stride = 2'(s);
    endtask

    task automatic new_run();
        hs_n     = 0;
        done_n   = 0;
        err_n    = 0;
        busy_n   = 0;
        first_hs = -1;
        last_hs  = -1;
        done_cyc = -1;
        err_cyc  = -1;
        last_r   = -1;
        last_c   = -1;
        acc_win.delete();
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        pos_t p;
        @(negedge clk);
        cyc++;
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (valid && ready) begin
            chk("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                p = exp_q.pop_front();
                chk("win_row", win_row, p.r);
                chk("win_col", win_col, p.c);
                chk("win_data", win, model_win(p.r, p.c));
            end
            if (hs_n == 0) first_hs = cyc;
            last_hs = cyc;
            last_r  = int'(win_row);
            last_c  = int'(win_col);
            hs_n++;
            acc_win.push_back(win);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int d0;
        int i;
        d0 = done_n;
        i  = 0;
        while (done_n == d0 && i < max) begin
            tick();
            i++;
        end
        chk(tag, done_n != d0, 1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_win"}, win, 0);
        chk({tag, "_row"}, win_row, 0);
        chk({tag, "_col"}, win_col, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t w;
        int   sc, d1;

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mtx[r][c] = pix(r, c);

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk_idle_zero("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 4x4, stride 1, ready high: four back-to-back windows
        new_run();
        set_dims(4, 4, 1);
        ready = 1'b1;
        push_run(4, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_valid_next", valid, 1);
        chk("t1_busy_next", busy, 1);
        wait_done("t1_done_seen", 20);
        chk("t1_count", hs_n, 4);
        chk("t1_back_to_back", last_hs - first_hs, 3);
        chk("t1_done_lat", done_cyc - last_hs, 1);
        w = acc_win[1];
        chk("t1_w1_00", w[0][0], 8'h01);
        chk("t1_w1_22", w[2][2], 8'h23);
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Same run with a 3-cycle stall on window (0,1)
        new_run();
        push_run(4, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_stall_valid", valid, 1);
            chk("t2_stall_row", win_row, 0);
            chk("t2_stall_col", win_col, 1);
            chk("t2_stall_win", win, model_win(0, 1));
        end
        ready = 1'b1;
        wait_done("t2_done_seen", 20);
        chk("t2_count", hs_n, 4);
        chk("t2_sb_empty", exp_q.size(), 0);

        // 7 wide x 5 high, stride 2: six windows
        new_run();
        set_dims(7, 5, 2);
        push_run(7, 5, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3_done_seen", 40);
        chk("t3_count", hs_n, 6);
        chk("t3_last_row", last_r, 2);
        chk("t3_last_col", last_c, 4);
        w = acc_win[5];
        chk("t3_last_22", w[2][2], 8'h46);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Too-narrow matrix: err pulse only
        new_run();
        set_dims(2, 8, 1);
        start = 1'b1;
        tick();
        sc = cyc;
        start = 1'b0;
        repeat (4) tick();
        chk("t4_err_lat", err_cyc, sc + 1);
        chk("t4_err_once", err_n, 1);
        chk("t4_no_window", hs_n, 0);
        chk("t4_no_busy", busy_n, 0);
        chk("t4_no_done", done_n, 0);

        // stride 0 behaves as 1 on a 3x3 matrix: single window
        new_run();
        set_dims(3, 3, 0);
        push_run(3, 3, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4b_done_seen", 10);
        chk("t4b_count", hs_n, 1);
        chk("t4b_done_lat", done_cyc - last_hs, 1);

        // start pulsed mid-run is ignored
        new_run();
        set_dims(4, 4, 1);
        push_run(4, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5_done_seen", 20);
        repeat (3) tick();
        chk("t5_count", hs_n, 4);
        chk("t5_no_restart", busy_n, 4);

        // start held high: second run begins the cycle after done
        new_run();
        set_dims(3, 3, 1);
        push_run(3, 3, 1);
        push_run(3, 3, 1);
        start = 1'b1;
        wait_done("t5b_done1", 10);
        d1 = done_cyc;
        tick();
        start = 1'b0;
        wait_done("t5b_done2", 10);
        chk("t5b_count", hs_n, 2);
        chk("t5b_restart_lat", last_hs, d1 + 2);
        chk("t5b_sb_empty", exp_q.size(), 0);

        // Asynchronous reset while window (1,0) is presented
        new_run();
        set_dims(4, 4, 1);
        push_run(4, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_pre_row", win_row, 1);
        chk("t6_pre_col", win_col, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_idle_zero("t6_rst");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_no_done", done_n, 0);
        new_run();
        push_run(4, 4, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_row", win_row, 0);
        chk("t6_restart_col", win_col, 0);
        chk("t6_restart_valid", valid, 1);
        wait_done("t6_done_seen", 20);
        chk("t6_count", hs_n, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
